// File: rtl/pipe_cla_adder_if.sv
// Operand/result handshake bundle for pipe_cla_adder.
// PIPE_ADDER_SAT_EN adds the per-operation saturate request.
interface pipe_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
`ifdef PIPE_ADDER_SAT_EN
  logic             saturate;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
`ifdef PIPE_ADDER_SAT_EN
    output saturate,
`endif
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
`ifdef PIPE_ADDER_SAT_EN
    input  saturate,
`endif
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready back-pressure.
// Define PIPE_ADDER_SAT_EN to enable signed saturation on overflow.
module pipe_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 8,
  parameter int STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  pipe_cla_adder_if.slave   bus
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int BPS  = NBLK / STAGES;

  // Rank s holds an operation waiting for stage s: operands (B already
  // inverted for subtract), low sum bits finished so far, and the carry in.
  logic [STAGES-1:0]            vld_q;
  logic [STAGES-1:0]            cry_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_q;
  logic [STAGES-1:0][WIDTH-1:0] opa_q;
  logic [STAGES-1:0][WIDTH-1:0] opb_q;
`ifdef PIPE_ADDER_SAT_EN
  logic [STAGES-1:0]            sat_q;
`endif

  logic             out_vld_q;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;

  logic [STAGES-1:0][WIDTH-1:0] st_sum;
  logic [STAGES-1:0]            st_cry;
  logic                         c_msb;
  logic                         adv;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. All ranks move together; the pipe stalls only when a result
  // is waiting and the consumer is not ready, so out_ready feeds in_ready.
  assign adv          = !out_vld_q || bus.out_ready;
  assign bus.in_ready = adv && !reset;

  assign bus.out_valid = out_vld_q;
  assign bus.sum       = out_sum_q;
  assign bus.cout      = out_cout_q;
  assign bus.overflow  = out_ovf_q;

  always_comb begin
    logic cc, ci, bg, bp, gi, pi;
    int   idx;
    st_sum = '0;
    st_cry = '0;
    c_msb  = 1'b0;
    cc = 1'b0; ci = 1'b0; bg = 1'b0; bp = 1'b0; gi = 1'b0; pi = 1'b0;
    idx = 0;
    for (int s = 0; s < STAGES; s++) begin
      st_sum[s] = sum_q[s];
      cc        = cry_q[s];
      for (int kb = 0; kb < BPS; kb++) begin
        bg = 1'b0;
        bp = 1'b1;
        ci = cc;
        for (int i = 0; i < BLOCK; i++) begin
          idx = (s * BPS + kb) * BLOCK + i;
          gi  = opa_q[s][idx] & opb_q[s][idx];
          pi  = opa_q[s][idx] ^ opb_q[s][idx];
          st_sum[s][idx] = pi ^ ci;
          if (idx == WIDTH - 1) c_msb = ci;
          ci = gi | (pi & ci);
          bg = gi | (pi & bg);
          bp = bp & pi;
        end
        // Block lookahead: next block's carry from this block's G/P only.
        cc = bg | (bp & cc);
      end
      st_cry[s] = cc;
    end
  end

  always_comb begin
    out_cout_d = st_cry[STAGES-1];
    out_ovf_d  = c_msb ^ st_cry[STAGES-1];
    out_sum_d  = st_sum[STAGES-1];
`ifdef PIPE_ADDER_SAT_EN
    if (sat_q[STAGES-1] && out_ovf_d) begin
      out_sum_d = opa_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q      <= '0;
      cry_q      <= '0;
      sum_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
`ifdef PIPE_ADDER_SAT_EN
      sat_q      <= '0;
`endif
      out_vld_q  <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= bus.in_valid && bus.in_ready;
      opa_q[0] <= bus.a;
      opb_q[0] <= bus.sub ? ~bus.b : bus.b;
      cry_q[0] <= bus.sub | bus.cin;
      sum_q[0] <= '0;
`ifdef PIPE_ADDER_SAT_EN
      sat_q[0] <= bus.saturate;
`endif
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        opa_q[s] <= opa_q[s-1];
        opb_q[s] <= opb_q[s-1];
        sum_q[s] <= st_sum[s-1];
        cry_q[s] <= st_cry[s-1];
`ifdef PIPE_ADDER_SAT_EN
        sat_q[s] <= sat_q[s-1];
`endif
      end
      out_vld_q  <= vld_q[STAGES-1];
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end
endmodule

// File: tb/tb_pipe_cla_adder.sv
// Directed bench for pipe_cla_adder: vector table on two configurations,
// plus back-pressure and mid-flight reset sequences.
module tb_pipe_cla_adder;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipe_cla_adder_if #(.WIDTH(W)) bus0 ();
  pipe_cla_adder_if #(.WIDTH(W)) bus1 ();

  pipe_cla_adder #(.WIDTH(W), .BLOCK(8), .STAGES(2)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  pipe_cla_adder #(.WIDTH(W), .BLOCK(4), .STAGES(4)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;
  bit           sb_en = 1'b0;
  int           sb_got = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic sat,
                         input logic [W-1:0] s, input logic co, input logic ov);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.sat = sat;
    v.exp_sum = s; v.exp_cout = co; v.exp_ovf = ov;
    vecs.push_back(v);
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic sat, input bit both);
    bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.sub = sub; bus0.in_valid = 1'b1;
`ifdef PIPE_ADDER_SAT_EN
    bus0.saturate = sat;
    bus1.saturate = sat;
`endif
    if (both) begin
      bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub; bus1.in_valid = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
  endtask

  // One operation into both pipes; check latency and results of each.
  task automatic run_vec(input vec_t v);
    int lat0, lat1;
    lat0 = -1;
    lat1 = -1;
    @(posedge clock); #1;
    drive_op(v.a, v.b, v.cin, v.sub, v.sat, 1'b1);
    @(negedge clock);
    check({v.name, "_in_ready0"}, bus0.in_ready, 1'b1);
    check({v.name, "_in_ready1"}, bus1.in_ready, 1'b1);
    @(posedge clock); #1;
    idle_inputs();
    for (int c = 0; c <= 12; c++) begin
      @(negedge clock);
      if (lat0 < 0 && bus0.out_valid) begin
        lat0 = c;
        check({v.name, "_sum0"}, bus0.sum, v.exp_sum);
        check({v.name, "_cout0"}, bus0.cout, v.exp_cout);
        check({v.name, "_ovf0"}, bus0.overflow, v.exp_ovf);
      end
      if (lat1 < 0 && bus1.out_valid) begin
        lat1 = c;
        check({v.name, "_sum1"}, bus1.sum, v.exp_sum);
        check({v.name, "_cout1"}, bus1.cout, v.exp_cout);
        check({v.name, "_ovf1"}, bus1.overflow, v.exp_ovf);
      end
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    check({v.name, "_latency0"}, lat0, 2);
    check({v.name, "_latency1"}, lat1, 4);
  endtask

  always @(negedge clock) begin
    if (sb_en && bus0.out_valid && bus0.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bp_extra: got result %h want no further result", bus0.sum);
      end else begin
        check("bp_order", bus0.sum, exp_q.pop_front());
        sb_got++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finish");
    $fatal(1);
  end

  initial begin
    int seen0, seen1;
    logic [W-1:0] held;
    bit ok;

    add_vec("intra_blk", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    add_vec("full_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
    add_vec("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    add_vec("ovf_neg_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
    add_vec("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    add_vec("ovf_neg_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
    add_vec("sub_borrow_c1", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    add_vec("sub_borrow_c0", 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    add_vec("add_cin", 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0);
    add_vec("sub_noborrow", 32'd7, 32'd5, 1'b0, 1'b1, 1'b0, 32'd2, 1'b1, 1'b0);
    add_vec("neg_wrap_nosat", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    add_vec("mixed", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0);
    add_vec("sub_zero", 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    add_vec("stage_cross", 32'h0000_FFFF, 32'h00FF_0001, 1'b0, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);

    // Reset state
    reset = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
    bus0.saturate = 1'b0;
    bus1.saturate = 1'b0;
`endif
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", bus0.in_ready, 1'b0);
    check("rst_out_valid", bus0.out_valid, 1'b0);
    check("rst_sum", bus0.sum, '0);
    check("rst_out_valid1", bus1.out_valid, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", bus0.in_ready, 1'b1);
    check("post_rst_in_ready1", bus1.in_ready, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: four back-to-back adds, 3-cycle stall on first result
    sb_en = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(W'(2 * i));
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          @(posedge clock); #1;
          drive_op(W'(i), W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
          ok = 1'b0;
          for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (bus0.in_ready) begin
              ok = 1'b1;
              break;
            end
          end
          check("bp_accept", ok, 1'b1);
        end
        @(posedge clock); #1;
        idle_inputs();
      end
      begin
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
          @(posedge clock); #2;
          if (bus0.out_valid) begin
            ok = 1'b1;
            break;
          end
        end
        check("bp_first_result", ok, 1'b1);
        bus0.out_ready = 1'b0;
        held = bus0.sum;
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          check("stall_in_ready", bus0.in_ready, 1'b0);
          check("stall_out_valid", bus0.out_valid, 1'b1);
          check("stall_sum", bus0.sum, held);
          @(posedge clock);
        end
        #2;
        bus0.out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 30; t++) begin
      @(negedge clock);
      if (exp_q.size() == 0) break;
    end
    repeat (4) @(negedge clock);
    check("bp_left", exp_q.size(), 0);
    check("bp_count", sb_got, 4);
    sb_en = 1'b0;

    // Reset with two operations in flight in both pipes
    @(posedge clock); #1;
    drive_op(32'd10, 32'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clock); #1;
    drive_op(32'd20, 32'd20, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clock); #1;
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    check("midrst_in_ready0", bus0.in_ready, 1'b0);
    check("midrst_in_ready1", bus1.in_ready, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_out_valid0", bus0.out_valid, 1'b0);
    check("midrst_sum0", bus0.sum, '0);
    check("midrst_flags0", {bus0.cout, bus0.overflow}, 2'b00);
    check("midrst_out_valid1", bus1.out_valid, 1'b0);
    check("midrst_sum1", bus1.sum, '0);
    check("midrst_in_ready_after", bus0.in_ready, 1'b1);
    seen0 = 0;
    seen1 = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      if (bus0.out_valid) seen0++;
      if (bus1.out_valid) seen1++;
    end
    check("midrst_ghost0", seen0, 0);
    check("midrst_ghost1", seen1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
